// File: rtl/ram_burst_reader.sv
// Burst read master for a registered-read dual-port RAM.
// Streams LEN consecutive words from BASE out on a valid/ready interface.
module ram_burst_reader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic                  r_wr_idx;
    logic                  r_rd_idx;
    logic [1:0]            r_count;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    logic [2:0]            w_occupancy;
    logic [1:0]            w_count_next;

    // Reads in flight are counted against the buffer so a returning word always has a slot.
    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_push       = r_inflight;
    assign w_pop        = (r_count != 2'd0) && m_ready;
    assign w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == S_READ) && (w_occupancy < 3'd2);
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (w_issue && (r_remaining == (ADDR_WIDTH+1)'(1))) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!r_inflight && (w_count_next == 2'd0)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
            r_wr_idx    <= 1'b0;
            r_rd_idx    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_accept) begin
                r_ptr       <= base_addr;
                r_remaining <= len;
            end else if (w_issue) begin
                r_ptr       <= r_ptr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_buf[r_wr_idx] <= ram_dout;
                r_wr_idx        <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_count <= w_count_next;
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign ram_addr_r = r_ptr;
    assign m_valid    = (r_count != 2'd0);
    assign m_data     = r_buf[r_rd_idx];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: RAM model, expected-word queue filled at start,
// and an independent monitor checking every stream beat and stall.
module tb_ram_burst_reader;

    localparam int AW    = 13;
    localparam int DW    = 7;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr_r;
    logic [DW-1:0] ram_dout = '0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] expQ [$];
    logic [DW-1:0] expWord;
    logic [DW-1:0] prevData;
    logic          prevStall = 1'b0;
    int            beatCycles [$];
    int            checks     = 0;
    int            errors     = 0;
    int            cyc        = 0;
    int            beatCount  = 0;
    int            doneCount  = 0;
    int            readyMode  = 2;

    ram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .ram_addr_r (ram_addr_r),
        .ram_dout   (ram_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    // Registered-read RAM: data appears the cycle after the address.
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr_r];
        cyc      <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", 32'(m_valid), 32'd1);
                checkOutput("stall_data", 32'(m_data), 32'(prevData));
            end
            if (m_valid && m_ready) begin
                checkOutput("beat_expected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    expWord = expQ.pop_front();
                    checkOutput("beat_data", 32'(m_data), 32'(expWord));
                end
                beatCount++;
                beatCycles.push_back(cyc);
            end
            if (done) doneCount++;
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
        end
    end

    // Sink: 0 = always ready, 1 = random with 5-cycle stalls, other = plain random.
    initial begin
        int stallLeft;
        stallLeft = 0;
        m_ready   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: m_ready = 1'b1;
                1: begin
                    if (stallLeft > 0) begin
                        m_ready = 1'b0;
                        stallLeft--;
                    end else if ($urandom_range(0, 7) == 0) begin
                        m_ready   = 1'b0;
                        stallLeft = 4;
                    end else begin
                        m_ready = 1'($urandom_range(0, 1));
                    end
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] b, input int n, input int mode, input bit restart);
        int s;
        int doneCyc;
        int limit;
        readyMode = mode;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        len       = n[AW:0];
        for (int i = 0; i < n; i++) expQ.push_back(mem[(int'(b) + i) % DEPTH]);
        beatCount = 0;
        beatCycles.delete();
        s = cyc;
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        len       = (AW+1)'($urandom);
        doneCyc   = -1;
        limit     = n * 40 + 60;
        for (int t = 0; t < limit; t++) begin
            @(negedge clk);
            if (t == 0) checkOutput("busy_after_start", 32'(busy), 32'd1);
            if (restart && t == 1) begin
                start     = 1'b1;
                base_addr = AW'($urandom);
                len       = (AW+1)'(3);
            end
            if (restart && t == 3) start = 1'b0;
            if (done) begin
                doneCyc = cyc;
                break;
            end
        end
        checkOutput("done_seen", 32'(doneCyc != -1), 32'd1);
        if (mode == 0 && doneCyc != -1) begin
            checkOutput("done_cycle", 32'(doneCyc - s), (n == 0) ? 32'd1 : 32'(n + 3));
            if (n > 0 && beatCycles.size() > 0) begin
                checkOutput("first_beat_cycle", 32'(beatCycles[0] - s), 32'd3);
                checkOutput("last_beat_cycle", 32'(beatCycles[beatCycles.size()-1] - s), 32'(n + 2));
            end
        end
        @(negedge clk);
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("beat_count", 32'(beatCount), 32'(n));
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("ptr_end", 32'(ram_addr_r), 32'((int'(b) + n) % DEPTH));
        expQ.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneBefore;
        for (int a = 0; a < DEPTH; a++) mem[a] = a[DW-1:0];
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;

        // Reset with random inputs: everything must read zero.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            start     = 1'($urandom);
            base_addr = AW'($urandom);
            len       = (AW+1)'($urandom);
            @(negedge clk);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_done", 32'(done), 32'd0);
            checkOutput("rst_valid", 32'(m_valid), 32'd0);
            checkOutput("rst_data", 32'(m_data), 32'd0);
            checkOutput("rst_addr", 32'(ram_addr_r), 32'd0);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idle_valid", 32'(m_valid), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
        end

        applyStimulus(13'h0010, 4, 0, 1'b0);
        applyStimulus(13'h1FFE, 4, 0, 1'b0);
        applyStimulus(AW'($urandom), 16, 1, 1'b0);

        for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(AW'($urandom), $urandom_range(1, 40), (k % 2) + 1, 1'b0);
        end

        applyStimulus(AW'($urandom), 0, 0, 1'b0);
        applyStimulus(13'h0100, 6, 1, 1'b1);
        applyStimulus(13'h0123, DEPTH, 0, 1'b0);

        // Abort after the third beat of an 8-word burst.
        readyMode = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = 13'h0040;
        len       = (AW+1)'(8);
        for (int i = 0; i < 8; i++) expQ.push_back(mem[(32'h40 + i) % DEPTH]);
        beatCount = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            if (beatCount >= 3) break;
        end
        #2;
        doneBefore = doneCount;
        rst_n      = 1'b0;
        #1;
        checkOutput("abort_beats", 32'(beatCount), 32'd3);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_valid", 32'(m_valid), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_data", 32'(m_data), 32'd0);
        checkOutput("abort_addr", 32'(ram_addr_r), 32'd0);
        expQ.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("abort_no_done", 32'(doneCount), 32'(doneBefore));
        checkOutput("abort_idle_busy", 32'(busy), 32'd0);
        applyStimulus(13'h00AB, 8, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
